// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared states, selector constants and defaults for the mult/div sequencer
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    WB    = 3'd3,
    EXC   = 3'd4,
    TMO   = 3'd5
  } state_e;

  localparam logic SEL_MULT = 1'b0;
  localparam logic SEL_DIV  = 1'b1;

  localparam int TIMEOUT_CYCLES_DEFAULT = 64;
  localparam int CNT_W_DEFAULT          = 7;

endpackage

// File: rtl/muldiv_cycle_cnt.sv
// rtl/muldiv_cycle_cnt.sv - saturating up-counter with synchronous clear and count enable
module muldiv_cycle_cnt
  import muldiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Clear has priority so a new op always starts counting from zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - start/wait/writeback sequencer between main FSM and mult/div units
// Optional RUN-state abort is compiled in with MULDIV_TIMEOUT_EN.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_W          = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_mult,
  input  logic             op_div,
  input  logic [31:0]      divisor,
  input  logic             mult_done,
  input  logic             div_done,
  output logic             mult_start,
  output logic             div_start,
  output logic             hilo_src,
  output logic             high_load,
  output logic             low_load,
  output logic             busy,
  output logic             done,
  output logic             div0_exc,
  output logic [CNT_W-1:0] run_cycles,
  output logic             timeout_exc
);

  if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_cfg_check
    $error("muldiv_sequencer: TIMEOUT_CYCLES must be below 2**CNT_W");
  end

  state_e state_q, state_d;
  logic   sel_q, sel_d;
  logic   unit_done;
  logic   tmo_hit;
  logic   cnt_clr, cnt_en;

  logic mult_start_q, mult_start_d;
  logic div_start_q, div_start_d;
  logic hilo_src_q, hilo_src_d;
  logic high_load_q, high_load_d;
  logic low_load_q, low_load_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic div0_exc_q, div0_exc_d;

  // Only the unit that was started may end the RUN wait.
  assign unit_done = (sel_q == SEL_DIV) ? div_done : mult_done;

`ifdef MULDIV_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  logic timeout_exc_q, timeout_exc_d;

  assign tmo_hit       = (run_cycles == TMO_LIMIT);
  assign timeout_exc_d = (state_d == TMO);

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_exc_q <= 1'b0;
    end else begin
      timeout_exc_q <= timeout_exc_d;
    end
  end

  assign timeout_exc = timeout_exc_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_exc = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (op_mult) begin
          sel_d   = SEL_MULT;
          state_d = START;
        end else if (op_div) begin
          if (divisor != 32'd0) begin
            sel_d   = SEL_DIV;
            state_d = START;
          end else begin
            state_d = EXC;
          end
        end
      end
      START: state_d = RUN;
      RUN: begin
        // A done in the same cycle as the limit still completes normally.
        if (unit_done) begin
          state_d = WB;
        end else if (tmo_hit) begin
          state_d = TMO;
        end
      end
      WB, EXC, TMO: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    mult_start_d = (state_d == START) && (sel_d == SEL_MULT);
    div_start_d  = (state_d == START) && (sel_d == SEL_DIV);
    high_load_d  = (state_d == WB);
    low_load_d   = (state_d == WB);
    done_d       = (state_d == WB);
    busy_d       = (state_d != IDLE);
    div0_exc_d   = (state_d == EXC);
    hilo_src_d   = hilo_src_q;
    if (state_d inside {START, RUN, WB}) begin
      hilo_src_d = sel_d;
    end
  end

  assign cnt_clr = (state_d == START);
  assign cnt_en  = (state_q == RUN);

  muldiv_cycle_cnt #(
    .CNT_W (CNT_W)
  ) u_run_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (run_cycles)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= SEL_MULT;
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
      hilo_src_q   <= 1'b0;
      high_load_q  <= 1'b0;
      low_load_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      div0_exc_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      mult_start_q <= mult_start_d;
      div_start_q  <= div_start_d;
      hilo_src_q   <= hilo_src_d;
      high_load_q  <= high_load_d;
      low_load_q   <= low_load_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      div0_exc_q   <= div0_exc_d;
    end
  end

  assign mult_start = mult_start_q;
  assign div_start  = div_start_q;
  assign hilo_src   = hilo_src_q;
  assign high_load  = high_load_q;
  assign low_load   = low_load_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign div0_exc   = div0_exc_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - randomized self-checking bench for muldiv_sequencer
// Build with MULDIV_TIMEOUT_EN defined to exercise the timeout abort instead of the long wait.
module tb_muldiv_sequencer;

  localparam int TB_TMO   = 8;
  localparam int TB_CNT_W = 7;
  localparam int RC_MAX   = (1 << TB_CNT_W) - 1;
  localparam int D_MAX    = TB_TMO + 2;
  localparam int K_WB     = 0;
  localparam int K_DIV0   = 1;
  localparam int K_TMO    = 2;

  logic                clk = 1'b0;
  logic                reset, op_mult, op_div, mult_done, div_done;
  logic [31:0]         divisor;
  logic                mult_start, div_start, hilo_src, high_load, low_load;
  logic                busy, done, div0_exc, timeout_exc;
  logic [TB_CNT_W-1:0] run_cycles;

  typedef struct packed {
    logic                ms;
    logic                ds;
    logic                hilo;
    logic                hl;
    logic                ll;
    logic                busy;
    logic                done;
    logic                d0;
    logic                tmo;
    logic [TB_CNT_W-1:0] rc;
  } vec_t;

  int   vectors     = 0;
  int   miscompares = 0;
  logic m_hilo      = 1'b0;
  int   m_rc        = 0;
  vec_t obs, exp_v;

  muldiv_sequencer #(
    .TIMEOUT_CYCLES (TB_TMO),
    .CNT_W          (TB_CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .op_mult     (op_mult),
    .op_div      (op_div),
    .divisor     (divisor),
    .mult_done   (mult_done),
    .div_done    (div_done),
    .mult_start  (mult_start),
    .div_start   (div_start),
    .hilo_src    (hilo_src),
    .high_load   (high_load),
    .low_load    (low_load),
    .busy        (busy),
    .done        (done),
    .div0_exc    (div0_exc),
    .run_cycles  (run_cycles),
    .timeout_exc (timeout_exc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  function automatic int sat(input int x);
    return (x > RC_MAX) ? RC_MAX : x;
  endfunction

  // Expected outputs c cycles after a request cycle (c=0). fin is the cycle of the
  // closing pulse: writeback, divide-by-zero exception, or timeout abort.
  function automatic vec_t model(input int c, input logic s, input int fin, input int kind);
    vec_t v;
    v      = '0;
    v.hilo = m_hilo;
    v.rc   = TB_CNT_W'(m_rc);
    if (c < 1) return v;
    if (kind == K_DIV0) begin
      v.busy = (c == 1);
      v.d0   = (c == 1);
      return v;
    end
    v.hilo = s;
    if (c > fin) begin
      v.rc = TB_CNT_W'(sat(fin - 2));
      return v;
    end
    v.busy = 1'b1;
    v.ms   = (c == 1) && !s;
    v.ds   = (c == 1) && s;
    v.rc   = (c == 1) ? '0 : TB_CNT_W'(sat(c - 2));
    if (c == fin) begin
      if (kind == K_WB) begin
        v.hl   = 1'b1;
        v.ll   = 1'b1;
        v.done = 1'b1;
      end else begin
        v.tmo = 1'b1;
      end
    end
    return v;
  endfunction

  task automatic commit(input logic s, input int fin, input int kind);
    if (kind != K_DIV0) begin
      m_hilo = s;
      m_rc   = sat(fin - 2);
    end
  endtask

  // Samples the outputs of the current cycle, then drives this cycle's inputs.
  task automatic tick(input logic rst, input logic om, input logic od, input logic [31:0] dv,
                      input logic md, input logic dd);
    @(negedge clk);
    obs = {mult_start, div_start, hilo_src, high_load, low_load, busy, done,
           div0_exc, timeout_exc, run_cycles};
    reset     = rst;
    op_mult   = om;
    op_div    = od;
    divisor   = dv;
    mult_done = md;
    div_done  = dd;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      tick(1'b1, c[0], ~c[0], 32'd0, 1'b1, 1'b1);
      vectors++;
      if (obs !== vec_t'(0)) begin
        miscompares++;
        $display("FAIL reset cyc %0d: got %b want %b", c, obs, vec_t'(0));
      end
    end
    m_hilo = 1'b0;
    m_rc   = 0;
    for (int c = 0; c < 2; c++) begin
      tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      exp_v = model(0, 1'b0, 0, K_WB);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL reset_release cyc %0d: got %b want %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_mult_basic();
    int d;
    d = 5;
    for (int c = 0; c <= d + 2; c++) begin
      tick(1'b0, c == 0, 1'b0, 32'd0, c == d, 1'b0);
      exp_v = model(c, 1'b0, d + 1, K_WB);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL mult_basic cyc %0d: got %b want %b", c, obs, exp_v);
      end
    end
    commit(1'b0, d + 1, K_WB);
  endtask

  task automatic test_div_basic();
    int d;
    d = 10;
    for (int c = 0; c <= d + 2; c++) begin
      tick(1'b0, 1'b0, c == 0, 32'd7, 1'b0, c == d);
      exp_v = model(c, 1'b1, d + 1, K_WB);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL div_basic cyc %0d: got %b want %b", c, obs, exp_v);
      end
    end
    commit(1'b1, d + 1, K_WB);
  endtask

  task automatic test_div_zero();
    for (int c = 0; c <= 3; c++) begin
      tick(1'b0, 1'b0, c == 0, 32'd0, 1'b0, c >= 1);
      exp_v = model(c, 1'b1, 1, K_DIV0);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL div_zero cyc %0d: got %b want %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_priority();
    int d;
    d = 6;
    for (int c = 0; c <= d + 2; c++) begin
      tick(1'b0, c == 0, (c == 0) || (c == 3), 32'h1234, c == d, c >= 1);
      exp_v = model(c, 1'b0, d + 1, K_WB);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL priority cyc %0d: got %b want %b", c, obs, exp_v);
      end
    end
    commit(1'b0, d + 1, K_WB);
  endtask

  // Minimum-latency ops with no idle gap; a request during WB must be dropped.
  task automatic test_back_to_back();
    logic s;
    for (int t = 0; t < 4; t++) begin
      s = t[0];
      for (int c = 0; c <= 3; c++) begin
        tick(1'b0, (c == 0) ? !s : (c == 3), (c == 0) ? s : (c == 3), 32'd9,
             !s && (c == 2), s && (c == 2));
        exp_v = model(c, s, 3, K_WB);
        vectors++;
        if (obs !== exp_v) begin
          miscompares++;
          $display("FAIL back_to_back op %0d cyc %0d: got %b want %b", t, c, obs, exp_v);
        end
      end
      commit(s, 3, K_WB);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] dv;
    dv = $urandom | 32'd1;
    for (int c = 0; c <= 3; c++) begin
      tick(c == 3, 1'b0, c == 0, dv, 1'b0, 1'b0);
      exp_v = model(c, 1'b1, 100, K_WB);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL reset_mid_run cyc %0d: got %b want %b", c, obs, exp_v);
      end
    end
    for (int c = 4; c <= 7; c++) begin
      tick(1'b0, 1'b0, 1'b0, dv, 1'b0, (c == 5) || (c == 6));
      vectors++;
      if (obs !== vec_t'(0)) begin
        miscompares++;
        $display("FAIL reset_mid_abort cyc %0d: got %b want %b", c, obs, vec_t'(0));
      end
    end
    m_hilo = 1'b0;
    m_rc   = 0;
    for (int c = 0; c <= 5; c++) begin
      tick(1'b0, c == 0, 1'b0, 32'd0, c == 3, 1'b0);
      exp_v = model(c, 1'b0, 4, K_WB);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL reset_mid_recover cyc %0d: got %b want %b", c, obs, exp_v);
      end
    end
    commit(1'b0, 4, K_WB);
  endtask

`ifdef MULDIV_TIMEOUT_EN
  task automatic test_timeout();
    int fin;
    // Done arriving exactly when the count reaches the limit still completes.
    for (int c = 0; c <= D_MAX + 2; c++) begin
      tick(1'b0, c == 0, 1'b0, 32'd0, c == D_MAX, 1'b0);
      exp_v = model(c, 1'b0, D_MAX + 1, K_WB);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL timeout_edge cyc %0d: got %b want %b", c, obs, exp_v);
      end
    end
    commit(1'b0, D_MAX + 1, K_WB);
    fin = TB_TMO + 3;
    for (int c = 0; c <= fin + 2; c++) begin
      tick(1'b0, c == 0, 1'b0, 32'd0, 1'b0, c >= 2);
      exp_v = model(c, 1'b0, fin, K_TMO);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL timeout cyc %0d: got %b want %b", c, obs, exp_v);
      end
    end
    commit(1'b0, fin, K_TMO);
  endtask
`else
  task automatic test_long_wait();
    int d;
    d = 140;
    for (int c = 0; c <= d + 2; c++) begin
      tick(1'b0, 1'b0, c == 0, 32'h8000_0000, c >= 2, c == d);
      exp_v = model(c, 1'b1, d + 1, K_WB);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL long_wait cyc %0d: got %b want %b", c, obs, exp_v);
      end
    end
    commit(1'b1, d + 1, K_WB);
  endtask
`endif

  task automatic test_random(input int n);
    int          gap, kind_r, d, kind, fin;
    logic        s, om, od, md, dd, sel_done, other;
    logic [31:0] dv;
    for (int t = 0; t < n; t++) begin
      gap    = int'($urandom_range(0, 2));
      kind_r = int'($urandom_range(0, 3));
      d      = int'($urandom_range(2, D_MAX));
      for (int g = 0; g < gap; g++) begin
        tick(1'b0, 1'b0, 1'b0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        exp_v = model(0, 1'b0, 0, K_WB);
        vectors++;
        if (obs !== exp_v) begin
          miscompares++;
          $display("FAIL random_idle op %0d: got %b want %b", t, obs, exp_v);
        end
      end
      dv = $urandom;
      if (kind_r == 2) dv = 32'd0;
      else if (dv == 32'd0) dv = 32'd1;
      s    = (kind_r == 1);
      kind = (kind_r == 2) ? K_DIV0 : K_WB;
      fin  = (kind == K_DIV0) ? 1 : d + 1;
      for (int c = 0; c <= fin; c++) begin
        if (c == 0) begin
          om = (kind_r == 0) || (kind_r == 3);
          od = (kind_r >= 1);
        end else begin
          om = 1'($urandom_range(0, 1));
          od = 1'($urandom_range(0, 1));
        end
        if (kind != K_DIV0 && c >= 2 && c <= d) sel_done = (c == d);
        else sel_done = 1'($urandom_range(0, 1));
        other = 1'($urandom_range(0, 1));
        md    = s ? other : sel_done;
        dd    = s ? sel_done : other;
        tick(1'b0, om, od, dv, md, dd);
        exp_v = model(c, s, fin, kind);
        vectors++;
        if (obs !== exp_v) begin
          miscompares++;
          $display("FAIL random op %0d kind %0d cyc %0d: got %b want %b", t, kind_r, c, obs, exp_v);
        end
      end
      commit(s, fin, kind);
    end
  endtask

  initial begin
    reset     = 1'b1;
    op_mult   = 1'b0;
    op_div    = 1'b0;
    divisor   = 32'd0;
    mult_done = 1'b0;
    div_done  = 1'b0;
    test_reset();
    test_mult_basic();
    test_div_basic();
    test_div_zero();
    test_priority();
    test_back_to_back();
    test_reset_mid_op();
`ifdef MULDIV_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random(60);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
